cache_control: RTL and testbench
================================

# cache_control

Sequencing controller for the LC-3b two-way set-associative, write-back, write-allocate cache. It sits between the CPU memory port and physical memory, and drives the load/select strobes of `cache_datapath` from the hit, valid, dirty and LRU status that the datapath reports for the addressed set. It also keeps saturating hit and miss counters for performance debug.

## Interface

Parameters:
- `CNT_WIDTH`, default 16: width of `hit_count` and `miss_count`.

Ports:
- `clk`: in, 1. Single clock; all state updates on the rising edge.
- `reset_n`: in, 1. Reset, synchronous, active-low.
- `mem_read`, `mem_write`: in, 1 each. CPU request strobes. Held until `mem_resp`.
- `mem_resp`: out, 1. CPU request complete.
- `pmem_read`, `pmem_write`: out, 1 each. Physical memory line read/write strobes.
- `pmem_resp`: in, 1. Physical memory transfer complete.
- `hit0`, `hit1`: in, 1 each. Way 0/1 of the addressed set is valid and its tag matches.
- `dirty0`, `dirty1`: in, 1 each. Way 0/1 dirty bit of the addressed set.
- `lru`: in, 1. Victim way of the addressed set.
- `way_sel`: out, 1. Way targeted by the data/tag/valid/dirty writes this cycle.
- `load_data`: out, 1. Write the data array at `way_sel`.
- `data_src`: out, 1. 0 = merge CPU write data under `mem_byte_enable`; 1 = full line from `pmem_rdata`.
- `load_tag`, `set_valid`, `set_dirty`, `clr_dirty`: out, 1 each. Metadata writes at `way_sel`.
- `load_lru`: out, 1. Write the LRU bit.
- `lru_in`: out, 1. Value written to LRU: the way not just used.
- `pmem_addr_sel`: out, 1. 0 = {CPU tag, set, 0}; 1 = {victim tag, set, 0}.
- `hit_count`, `miss_count`: out, `CNT_WIDTH` each. Saturating counters.

## Operation

- FSM has three states.
  - **IDLE**: the check state.
  - **WRITEBACK**: write the dirty victim back.
  - **FILL**: read the missing line.
- Request decode:
  - `req = mem_read | mem_write`.
  - If both strobes are high, it is a write.
  - `hit = hit0 | hit1`.
  - Hit way = 0 if `hit0`, else 1. Both hit bits high is illegal; way 0 is used.
- **IDLE, req and hit**:
  - Assert `mem_resp`, `load_lru`, with `lru_in` = the way other than the hit way.
  - On a write, also assert `load_data` (`data_src` = 0), `set_dirty`, and `way_sel` = hit way.
  - Stay in IDLE.
- **IDLE, req and miss**:
  - Go to WRITEBACK if the victim is dirty (`dirty0` when `lru` = 0, `dirty1` when `lru` = 1).
  - Otherwise go to FILL.
  - Latch the victim way (`lru`) into `victim_q`.
  - Set `miss_pending`.
- **WRITEBACK**:
  - Assert `pmem_write`, `pmem_addr_sel` = 1, `way_sel` = `victim_q`.
  - On `pmem_resp`, go to FILL.
- **FILL**:
  - Assert `pmem_read`, `pmem_addr_sel` = 0, `way_sel` = `victim_q`.
  - On `pmem_resp`: pulse `load_data` (`data_src` = 1), `load_tag`, `set_valid`, `clr_dirty` for one cycle, then go to IDLE.
  - IDLE then re-checks the request, which now hits and completes through the hit path (write merge included).
- Counters:
  - `miss_count` increments on each IDLE→WRITEBACK or IDLE→FILL transition.
  - `hit_count` increments on each `mem_resp` with `miss_pending` = 0.
  - `miss_pending` clears on `mem_resp`.
  - Both counters saturate at all-ones.
- If the CPU drops its request mid-miss, the physical memory transfer still completes. The FSM returns to IDLE and issues no `mem_resp`.
- When not explicitly asserted, every output strobe is 0. `way_sel`, `data_src` and `pmem_addr_sel` are 0 in IDLE with no request.

## Timing

- `mem_resp` and the IDLE hit-path strobes are combinational from state and inputs (Mealy).
- `pmem_read`, `pmem_write`, `pmem_addr_sel` and `way_sel` in WRITEBACK/FILL are functions of state and `victim_q` only (Moore). They stay stable until `pmem_resp`.
- Latency, counted in `clk` cycles from the first IDLE cycle with `req`, up to and including the `mem_resp` cycle:
  - Hit: 1.
  - Clean miss: 2 + Nf, where Nf = cycles FILL waits through `pmem_resp`.
  - Dirty miss: 2 + Nw + Nf.
- The fill-completion cycle writes the arrays. The following IDLE cycle sees the updated `hit`.
- Reset (`reset_n` = 0 at a rising edge), from any state including mid-WRITEBACK/FILL:
  - Next state IDLE; `victim_q` = 0; `miss_pending` = 0; counters = 0.
  - All strobes are low from the first cycle after the edge. An outstanding physical memory transfer is abandoned.
- `pmem_resp` in IDLE is ignored.

## Test plan

- **Reset:** hold `reset_n` = 0 for 2 cycles while in FILL → next cycle `pmem_read` = 0, `mem_resp` = 0, `hit_count` = `miss_count` = 0.
- **Read hit:** `mem_read` = 1, `hit1` = 1 → `mem_resp` = 1 same cycle; `load_lru` = 1, `lru_in` = 0; `hit_count` = 1 next cycle.
- **Write hit:** `mem_write` = 1, `hit0` = 1 → same cycle `load_data` = 1, `data_src` = 0, `set_dirty` = 1, `way_sel` = 0, `lru_in` = 1.
- **Clean read miss:** `lru` = 1, `dirty1` = 0, `pmem_resp` after 3 FILL cycles → `pmem_read` high 3 cycles with `way_sel` = 1; completion cycle `load_tag` = `set_valid` = `load_data` = 1, `data_src` = 1. Drive `hit1` = 1 from the next IDLE cycle → `mem_resp` there, total 5 cycles; `miss_count` = 1, `hit_count` unchanged.
- **Dirty write miss:** `lru` = 0, `dirty0` = 1 → `pmem_write` with `pmem_addr_sel` = 1 until `pmem_resp`, then `pmem_read` with `pmem_addr_sel` = 0, then IDLE write merge with `set_dirty` = 1; `miss_count` = 1.
- **Saturation and abandon:** preload `hit_count` to 16'hFFFF with 65535 hits, then one more hit → `hit_count` stays 16'hFFFF. Separately, deassert `mem_read` during FILL → `pmem_read` held until `pmem_resp`, return to IDLE, no `mem_resp`.

Source files
------------

// File: rtl/cache_control.sv
// Sequencing controller for the LC-3b two-way set-associative write-back cache.
// Drives datapath load/select strobes and the physical memory handshake from set status.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 dirty0,
  input  logic                 dirty1,
  input  logic                 lru,
  output logic                 way_sel,
  output logic                 load_data,
  output logic                 data_src,
  output logic                 load_tag,
  output logic                 set_valid,
  output logic                 set_dirty,
  output logic                 clr_dirty,
  output logic                 load_lru,
  output logic                 lru_in,
  output logic                 pmem_addr_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  // state     | meaning
  // IDLE      | check request; complete hits, start misses
  // WRITEBACK | write dirty victim line to pmem
  // FILL      | read missing line from pmem into victim way
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic                 victim_q, victim_d;
  logic                 miss_pending_q, miss_pending_d;
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  logic req;
  logic hit;
  logic hit_way;
  logic victim_dirty;
  logic miss_start;

  assign req          = mem_read | mem_write;
  assign hit          = hit0 | hit1;
  // hit0 takes precedence if both ways claim a hit
  assign hit_way      = ~hit0;
  assign victim_dirty = lru ? dirty1 : dirty0;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      victim_q       <= 1'b0;
      miss_pending_q <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      victim_q       <= victim_d;
      miss_pending_q <= miss_pending_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    miss_pending_d = miss_pending_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    miss_start     = 1'b0;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    way_sel        = 1'b0;
    load_data      = 1'b0;
    data_src       = 1'b0;
    load_tag       = 1'b0;
    set_valid      = 1'b0;
    set_dirty      = 1'b0;
    clr_dirty      = 1'b0;
    load_lru       = 1'b0;
    lru_in         = 1'b0;
    pmem_addr_sel  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          lru_in   = ~hit_way;
          if (mem_write) begin
            load_data = 1'b1;
            set_dirty = 1'b1;
            way_sel   = hit_way;
          end
        end else if (req) begin
          miss_start = 1'b1;
          victim_d   = lru;
          state_d    = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          load_data = 1'b1;
          data_src  = 1'b1;
          load_tag  = 1'b1;
          set_valid = 1'b1;
          clr_dirty = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response that closes out a miss is not counted as a hit
    if (mem_resp) begin
      miss_pending_d = 1'b0;
      if (!miss_pending_q && hit_count_q != CNT_MAX) hit_count_d = hit_count_q + CNT_ONE;
    end
    if (miss_start) begin
      miss_pending_d = 1'b1;
      if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: per-cycle vector table with a scoreboard queue,
// plus hand-written reset-in-FILL and hit counter saturation sequences.
module tb_cache_control;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, mem_read, mem_write, pmem_resp, hit0, hit1, dirty0, dirty1, lru;
  logic mem_resp, pmem_read, pmem_write, way_sel, load_data, data_src, load_tag;
  logic set_valid, set_dirty, clr_dirty, load_lru, lru_in, pmem_addr_sel;
  logic [CW-1:0] hit_count, miss_count;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
    .lru(lru), .way_sel(way_sel), .load_data(load_data), .data_src(data_src),
    .load_tag(load_tag), .set_valid(set_valid), .set_dirty(set_dirty),
    .clr_dirty(clr_dirty), .load_lru(load_lru), .lru_in(lru_in),
    .pmem_addr_sel(pmem_addr_sel), .hit_count(hit_count), .miss_count(miss_count)
  );

  // outs = {resp, prd, pwr, wsel, ldata, dsrc, ltag, sval, sdirty, cdirty, llru, lruin, asel}
  logic [12:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, way_sel, load_data, data_src, load_tag,
                 set_valid, set_dirty, clr_dirty, load_lru, lru_in, pmem_addr_sel};

  // in = {rd, wr, h0, h1, d0, d1, lru, presp}
  typedef struct {
    logic [7:0]  in;
    logic [12:0] out;
    int          hc;
    int          mc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [12:0] out;
    int          hc;
    int          mc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] i, input logic [12:0] o, input int hc, input int mc);
    vec_t v;
    v.in = i; v.out = o; v.hc = hc; v.mc = mc;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] i);
    {mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp} = i;
  endtask

  localparam logic [12:0] O_NONE  = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] O_RH0   = 13'b1_0_0_0_0_0_0_0_0_0_1_1_0;
  localparam logic [12:0] O_RH1   = 13'b1_0_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] O_WH0   = 13'b1_0_0_0_1_0_0_0_1_0_1_1_0;
  localparam logic [12:0] O_WH1   = 13'b1_0_0_1_1_0_0_0_1_0_1_0_0;
  localparam logic [12:0] O_FL0   = 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] O_FL1   = 13'b0_1_0_1_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] O_FD0   = 13'b0_1_0_0_1_1_1_1_0_1_0_0_0;
  localparam logic [12:0] O_FD1   = 13'b0_1_0_1_1_1_1_1_0_1_0_0_0;
  localparam logic [12:0] O_WB0   = 13'b0_0_1_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] O_WB1   = 13'b0_0_1_1_0_0_0_0_0_0_0_0_1;

  initial begin
    exp_t e;

    add(8'b0000_0000, O_NONE, 0, 0);  // idle
    add(8'b1001_0000, O_RH1,  0, 0);  // read hit way1
    add(8'b0110_0000, O_WH0,  1, 0);  // write hit way0
    add(8'b0101_0000, O_WH1,  2, 0);  // write hit way1
    add(8'b1011_0000, O_RH0,  3, 0);  // both hit bits: way0
    add(8'b1101_0000, O_WH1,  4, 0);  // read+write is a write
    add(8'b0000_0001, O_NONE, 5, 0);  // pmem_resp in idle ignored
    // clean read miss, lru=1, dirty0=1 must not matter
    add(8'b1000_1010, O_NONE, 5, 0);
    add(8'b1000_1010, O_FL1,  5, 1);
    add(8'b1000_1010, O_FL1,  5, 1);
    add(8'b1000_1011, O_FD1,  5, 1);
    add(8'b1001_0000, O_RH1,  5, 1);
    add(8'b0000_0000, O_NONE, 5, 1);
    // dirty write miss, lru=0
    add(8'b0100_1000, O_NONE, 5, 1);
    add(8'b0100_1000, O_WB0,  5, 2);
    add(8'b0100_1001, O_WB0,  5, 2);
    add(8'b0100_1001, O_FD0,  5, 2);
    add(8'b0110_0000, O_WH0,  5, 2);
    add(8'b0000_0000, O_NONE, 5, 2);
    add(8'b1010_0000, O_RH0,  5, 2);
    // dirty read miss, lru=1; lru input changes mid-miss, victim stays latched
    add(8'b1000_0110, O_NONE, 6, 2);
    add(8'b1000_0101, O_WB1,  6, 3);
    add(8'b1000_0101, O_FD1,  6, 3);
    add(8'b1001_0000, O_RH1,  6, 3);
    // abandoned miss: request drops during FILL
    add(8'b1000_0100, O_NONE, 6, 3);
    add(8'b0000_0100, O_FL0,  6, 4);
    add(8'b0000_0100, O_FL0,  6, 4);
    add(8'b0000_0101, O_FD0,  6, 4);
    add(8'b0010_0001, O_NONE, 6, 4);
    add(8'b0000_0000, O_NONE, 6, 4);

    reset_n = 1'b0;
    drive(8'b0);
    tick();
    tick();
    @(negedge clk);
    chk("reset outs", outs, O_NONE);
    chk("reset hit_count", hit_count, 0);
    chk("reset miss_count", miss_count, 0);
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) tick();
      drive(vecs[i].in);
      e.idx = i; e.out = vecs[i].out; e.hc = vecs[i].hc; e.mc = vecs[i].mc;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d outs", e.idx), outs, e.out);
      chk($sformatf("vec%0d hit_count", e.idx), hit_count, e.hc);
      chk($sformatf("vec%0d miss_count", e.idx), miss_count, e.mc);
    end

    // reset while in FILL
    tick();
    drive(8'b1000_0000);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("pre-reset in fill pmem_read", pmem_read, 1);
    tick();
    @(negedge clk);
    chk("post-reset pmem_read", pmem_read, 0);
    chk("post-reset mem_resp", mem_resp, 0);
    chk("post-reset hit_count", hit_count, 0);
    chk("post-reset miss_count", miss_count, 0);
    tick();
    reset_n = 1'b1;
    drive(8'b0);
    @(negedge clk);
    chk("after reset outs", outs, O_NONE);

    // hit counter saturation
    tick();
    drive(8'b1010_0000);
    for (int i = 0; i < 65535; i++) tick();
    @(negedge clk);
    chk("sat hit_count at max", hit_count, 16'hFFFF);
    chk("sat mem_resp", mem_resp, 1);
    tick();
    @(negedge clk);
    chk("sat hit_count held", hit_count, 16'hFFFF);
    chk("sat miss_count", miss_count, 0);
    drive(8'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
